// File: rtl/datapath_decoder_if.sv
// Bundles the decoder request, operand and result signals.
// The testbench drives the master side and the decoder takes the slave side.
interface datapath_decoder_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] T;
  logic [W-1:0] B;
  logic [W-1:0] C;
  logic         E;
  logic         shr_in;
  logic         lshl;
  logic [W-1:0] A_out;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    output start, T, B, C, E, shr_in, lshl,
    input  A_out, busy, done, err
  );

  modport slave (
    input  start, T, B, C, E, shr_in, lshl,
    output A_out, busy, done, err
  );
endinterface

// File: rtl/datapath_decoder.sv
// Inverse of the shift/add-sub datapath.
// The encoder produced T = {S[W-2:0], lshl}, where S = A+B-C (E=0) or A-B+C (E=1).
// This block undoes that in three steps:
//   SHIFT : shift right, restoring the dropped MSB from shr_in
//   STEP1 : undo the B term
//   STEP2 : undo the C term, then publish A
// All arithmetic wraps modulo 2^W.
// Every operand is captured when start is accepted, so later input changes
// cannot disturb an operation that is already in flight.
module datapath_decoder #(
  parameter int W = 8
) (
  input logic              CLK,
  input logic              Clr,
  datapath_decoder_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_STEP1 = 3'd2,
    ST_STEP2 = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t       state_r;
  state_t       state_s;

  logic [W-1:0] r_r;
  logic [W-1:0] b_cap_r;
  logic [W-1:0] c_cap_r;
  logic         e_cap_r;
  logic         shr_cap_r;
  logic [W-1:0] a_out_r;
  logic         err_r;
  logic         busy_r;
  logic         done_r;

  logic [W-1:0] shift_s;
  logic [W-1:0] step1_s;
  logic [W-1:0] step2_s;

  // Undo B: the encoder added B when E=0 and subtracted it when E=1.
  function automatic logic [W-1:0] undo_b(input logic [W-1:0] r,
                                          input logic [W-1:0] b,
                                          input logic         e);
    logic [W-1:0] res;
    if (e) begin
      res = r + b;
    end else begin
      res = r - b;
    end
    return res;
  endfunction

  // Undo C: the encoder subtracted C when E=0 and added it when E=1.
  function automatic logic [W-1:0] undo_c(input logic [W-1:0] r,
                                          input logic [W-1:0] c,
                                          input logic         e);
    logic [W-1:0] res;
    if (e) begin
      res = r - c;
    end else begin
      res = r + c;
    end
    return res;
  endfunction

  // State register.
  always_ff @(posedge CLK or negedge Clr) begin
    if (!Clr) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  // start is honoured only in IDLE; a start seen in any other state is dropped.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: state_s = ST_STEP1;
      ST_STEP1: state_s = ST_STEP2;
      ST_STEP2: state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Per-step results, computed from the working register and the captured operands.
  always_comb begin
    shift_s = {shr_cap_r, r_r[W-1:1]};
    step1_s = undo_b(r_r, b_cap_r, e_cap_r);
    step2_s = undo_c(r_r, c_cap_r, e_cap_r);
  end

  // Working register, operand capture, and the sticky A_out/err results.
  always_ff @(posedge CLK or negedge Clr) begin
    if (!Clr) begin
      r_r       <= {W{1'b0}};
      b_cap_r   <= {W{1'b0}};
      c_cap_r   <= {W{1'b0}};
      e_cap_r   <= 1'b0;
      shr_cap_r <= 1'b0;
      a_out_r   <= {W{1'b0}};
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            r_r       <= bus.T;
            b_cap_r   <= bus.B;
            c_cap_r   <= bus.C;
            e_cap_r   <= bus.E;
            shr_cap_r <= bus.shr_in;
            err_r     <= bus.T[0] ^ bus.lshl;
          end
        end
        ST_SHIFT: r_r <= shift_s;
        ST_STEP1: r_r <= step1_s;
        ST_STEP2: begin
          r_r     <= step2_s;
          a_out_r <= step2_s;
        end
        ST_DONE:  r_r <= r_r;
        default:  r_r <= r_r;
      endcase
    end
  end

  // Registered busy/done flags, derived from the state being entered.
  always_ff @(posedge CLK or negedge Clr) begin
    if (!Clr) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == ST_SHIFT) || (state_s == ST_STEP1) ||
                (state_s == ST_STEP2);
      done_r <= (state_s == ST_DONE);
    end
  end

  assign bus.A_out = a_out_r;
  assign bus.err   = err_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_datapath_decoder.sv
// Testbench for datapath_decoder.
// Part 1 applies a table of fixed vectors.
// Part 2 runs hand-written sequences: ignored starts, an operand change in
// flight, and a mid-operation reset.
// Part 3 checks random encode/decode round trips against a simple encoder model.
module tb_datapath_decoder;

  localparam int W = 8;

  logic clk;
  logic clr;

  datapath_decoder_if #(.W(W)) bus ();

  datapath_decoder #(.W(W)) dut (
    .CLK (clk),
    .Clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  // Count done pulses on the falling edge, away from the register updates.
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
  end

  typedef struct {
    logic [7:0] t;
    logic [7:0] b;
    logic [7:0] c;
    logic       e;
    logic       shr;
    logic       l;
    logic [7:0] exp_a;
    logic       exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_ops(input logic [7:0] t, input logic [7:0] b, input logic [7:0] c,
                           input logic e, input logic shr, input logic l);
    bus.T      = t;
    bus.B      = b;
    bus.C      = c;
    bus.E      = e;
    bus.shr_in = shr;
    bus.lshl   = l;
  endtask

  // Run one operation.
  // Returns the edges from acceptance to done (expected 3), the busy value
  // seen right after acceptance, and the results. The task finishes in IDLE.
  task automatic run_op(input logic [7:0] t, input logic [7:0] b, input logic [7:0] c,
                        input logic e, input logic shr, input logic l,
                        output logic [7:0] a, output logic er, output int lat,
                        output logic busy0);
    drive_ops(t, b, c, e, shr, l);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    busy0 = bus.busy;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    a  = bus.A_out;
    er = bus.err;
    @(posedge clk); #1;
  endtask

  logic [7:0] a_got;
  logic       e_got;
  logic       b0;
  int         lat;
  int         dc0;

  initial begin
    clr = 1'b0;
    bus.start = 1'b0;
    drive_ops(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    //                t      b      c      e     shr   l     A      err
    vecs[0] = '{8'd6,  8'd4,  8'd3,  1'b0, 1'b0, 1'b0, 8'd2,  1'b0};
    vecs[1] = '{8'd2,  8'd4,  8'd3,  1'b1, 1'b0, 1'b0, 8'd2,  1'b0};
    vecs[2] = '{8'hFE, 8'd1,  8'd0,  1'b0, 1'b1, 1'b0, 8'hFE, 1'b0};
    vecs[3] = '{8'd7,  8'd4,  8'd3,  1'b0, 1'b0, 1'b0, 8'd2,  1'b1};
    vecs[4] = '{8'h00, 8'd0,  8'd0,  1'b0, 1'b1, 1'b0, 8'h80, 1'b0};
    vecs[5] = '{8'h01, 8'd5,  8'd2,  1'b1, 1'b0, 1'b1, 8'd3,  1'b0};
    vecs[6] = '{8'h10, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h0A, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_A_out", {24'd0, bus.A_out}, 32'd0);
    check("reset_busy",  {31'd0, bus.busy},  32'd0);
    check("reset_done",  {31'd0, bus.done},  32'd0);
    check("reset_err",   {31'd0, bus.err},   32'd0);
    clr = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].t, vecs[i].b, vecs[i].c, vecs[i].e, vecs[i].shr, vecs[i].l,
             a_got, e_got, lat, b0);
      check($sformatf("vec%0d_A_out", i),   {24'd0, a_got}, {24'd0, vecs[i].exp_a});
      check($sformatf("vec%0d_err", i),     {31'd0, e_got}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_latency", i), lat, 32'd3);
      check($sformatf("vec%0d_busy", i),    {31'd0, b0},    32'd1);
      check($sformatf("vec%0d_done_clr", i), {31'd0, bus.done}, 32'd0);
    end

    // start held through SHIFT..DONE is ignored; B changed mid-operation.
    dc0 = done_cnt;
    drive_ops(8'd6, 8'd4, 8'd3, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;                 // accepted, now in SHIFT
    bus.B = 8'hAA;
    bus.T = 8'h55;
    bus.E = 1'b1;
    @(posedge clk); #1;                 // STEP1
    @(posedge clk); #1;                 // STEP2
    @(posedge clk); #1;                 // DONE
    check("seq_done_pulse", {31'd0, bus.done}, 32'd1);
    check("seq_busy_in_done", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;                 // start seen in DONE is dropped; now IDLE
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("seq_one_done", done_cnt - dc0, 32'd1);
    check("seq_A_out_hold", {24'd0, bus.A_out}, 32'd2);
    check("seq_idle_busy", {31'd0, bus.busy}, 32'd0);

    // Reset asserted during STEP1.
    dc0 = done_cnt;
    drive_ops(8'd7, 8'd4, 8'd3, 1'b0, 1'b0, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;                 // SHIFT
    bus.start = 1'b0;
    check("clr_err_set", {31'd0, bus.err}, 32'd1);
    @(posedge clk); #1;                 // STEP1
    clr = 1'b0;
    #1;
    check("clr_A_out", {24'd0, bus.A_out}, 32'd0);
    check("clr_busy",  {31'd0, bus.busy},  32'd0);
    check("clr_err",   {31'd0, bus.err},   32'd0);
    @(posedge clk); #1;
    clr = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("clr_no_done", done_cnt - dc0, 32'd0);
    check("clr_done_low", {31'd0, bus.done}, 32'd0);
    run_op(8'd6, 8'd4, 8'd3, 1'b0, 1'b0, 1'b0, a_got, e_got, lat, b0);
    check("clr_rerun_A_out", {24'd0, a_got}, 32'd2);
    check("clr_rerun_latency", lat, 32'd3);

    // Random round trips through a model of the encoder.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] a, b, c, s, t;
      logic       e, l, t0, exp_err;
      a  = 8'($urandom);
      b  = 8'($urandom);
      c  = 8'($urandom);
      e  = 1'($urandom_range(0, 1));
      l  = 1'($urandom_range(0, 1));
      t0 = 1'($urandom_range(0, 1));
      if (e) s = a - b + c;
      else   s = a + b - c;
      t = {s[6:0], t0};
      exp_err = (t0 != l);
      run_op(t, b, c, e, s[7], l, a_got, e_got, lat, b0);
      check($sformatf("rt%0d_A_out", i), {24'd0, a_got}, {24'd0, a});
      check($sformatf("rt%0d_err", i),   {31'd0, e_got}, {31'd0, exp_err});
      check($sformatf("rt%0d_latency", i), lat, 32'd3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
